// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hz_state_e;

  localparam logic [4:0]  REG_ZERO   = 5'd0;
  localparam int unsigned MC_W_DEF   = 4;
  localparam int unsigned PERF_W_DEF = 16;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; master is the pipeline side.
interface hazard_ctrl_if #(
  parameter int unsigned MC_W   = 4,
  parameter int unsigned PERF_W = 16
);

  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic [4:0]        ex_rd;
  logic              ex_mem_read;
  logic              ex_branch_taken;
  logic              ex_jump;
  logic              ex_mc_start;
  logic [MC_W-1:0]   ex_mc_cycles;
  logic              stall_if;
  logic              stall_id;
  logic              stall_ex;
  logic              flush_id;
  logic              flush_ex;
  logic              mc_busy;
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_jump, ex_mc_start, ex_mc_cycles,
    input  stall_if, stall_id, stall_ex, flush_id, flush_ex, mc_busy,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_jump, ex_mc_start, ex_mc_cycles,
    output stall_if, stall_id, stall_ex, flush_id, flush_ex, mc_busy,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: redirect flush, multi-cycle EX hold, load-use bubble.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MC_W   = MC_W_DEF,
  parameter int unsigned PERF_W = PERF_W_DEF
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hz
);

  hz_state_e         state_q;
  hz_state_e         state_d;
  logic [MC_W-1:0]   mc_cnt_q;
  logic [MC_W-1:0]   mc_cnt_d;

  logic              lu_match;
  logic              redirect;
  logic              stall_if;
  logic              stall_id;
  logic              stall_ex;
  logic              flush_id;
  logic              flush_ex;
  logic              mc_busy;
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] flush_cnt;

  assign lu_match = hz.ex_mem_read && (hz.ex_rd != REG_ZERO) &&
                    ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    redirect = 1'b0;
    stall_if = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    mc_busy  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (hz.ex_branch_taken || hz.ex_jump) begin
          redirect = 1'b1;
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end else if (hz.ex_mc_start && (hz.ex_mc_cycles != '0)) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
          state_d  = MC_WAIT;
          mc_cnt_d = hz.ex_mc_cycles;
        end else if (lu_match) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
      end
      MC_WAIT: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
        mc_busy  = 1'b1;
        if (mc_cnt_q <= MC_W'(1)) begin
          state_d  = RUN;
          mc_cnt_d = '0;
        end else begin
          mc_cnt_d = mc_cnt_q - MC_W'(1);
        end
      end
      default: begin
        state_d  = RUN;
        mc_cnt_d = '0;
      end
    endcase

    // Outputs are combinational, so they must be forced low while reset is held.
    if (!rst_n) begin
      redirect = 1'b0;
      stall_if = 1'b0;
      stall_id = 1'b0;
      stall_ex = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
      mc_busy  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_if),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect),
    .count (flush_cnt)
  );

  assign hz.stall_if  = stall_if;
  assign hz.stall_id  = stall_id;
  assign hz.stall_ex  = stall_ex;
  assign hz.flush_id  = flush_id;
  assign hz.flush_ex  = flush_ex;
  assign hz.mc_busy   = mc_busy;
  assign hz.stall_cnt = stall_cnt;
  assign hz.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: single-cycle vector table plus multi-cycle sequences.
module tb_hazard_ctrl;

  logic clk;
  logic rst_n;

  hazard_ctrl_if #(.MC_W(4), .PERF_W(16)) hz ();
  hazard_ctrl_if #(.MC_W(4), .PERF_W(4))  sz ();

  hazard_ctrl #(.MC_W(4), .PERF_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  hazard_ctrl #(.MC_W(4), .PERF_W(4)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (sz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output bits are ordered {stall_if, stall_id, stall_ex, flush_id, flush_ex, mc_busy}.
  localparam logic [5:0] O_IDLE = 6'b000000;
  localparam logic [5:0] O_LU   = 6'b110010;
  localparam logic [5:0] O_RED  = 6'b000110;
  localparam logic [5:0] O_MCS  = 6'b111000;
  localparam logic [5:0] O_MCW  = 6'b111001;

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       bt;
    logic       jp;
    logic       mcs;
    logic [3:0] mcc;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;
  int   exp_stall;
  int   exp_flush;

  function automatic vec_t mk(string name, logic [4:0] rs1, logic [4:0] rs2,
                              logic u1, logic u2, logic [4:0] rd, logic mr,
                              logic bt, logic jp, logic mcs, logic [3:0] mcc,
                              logic [5:0] exp);
    vec_t v;
    v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.mr = mr; v.bt = bt; v.jp = jp; v.mcs = mcs; v.mcc = mcc; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    hz.id_rs1          = v.rs1;
    hz.id_rs2          = v.rs2;
    hz.id_uses_rs1     = v.u1;
    hz.id_uses_rs2     = v.u2;
    hz.ex_rd           = v.rd;
    hz.ex_mem_read     = v.mr;
    hz.ex_branch_taken = v.bt;
    hz.ex_jump         = v.jp;
    hz.ex_mc_start     = v.mcs;
    hz.ex_mc_cycles    = v.mcc;
  endtask

  task automatic check_out(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = {hz.stall_if, hz.stall_id, hz.stall_ex, hz.flush_id, hz.flush_ex, hz.mc_busy};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s outputs: got %b want %b", name, got, exp);
    end
  endtask

  task automatic check_cnt(input string name);
    checks++;
    if ((hz.stall_cnt !== 16'(exp_stall)) || (hz.flush_cnt !== 16'(exp_flush))) begin
      errors++;
      $display("FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
               name, hz.stall_cnt, hz.flush_cnt, exp_stall, exp_flush);
    end
  endtask

  // Drive one cycle, check outputs mid-cycle, then update model and check counters after the edge.
  task automatic step(input vec_t v);
    drive(v);
    #1;
    check_out(v.name, v.exp);
    if (v.exp[5]) exp_stall++;
    if (v.exp[2]) exp_flush++;
    @(posedge clk);
    #1;
    check_cnt(v.name);
  endtask

  vec_t idle;

  initial begin
    checks    = 0;
    errors    = 0;
    exp_stall = 0;
    exp_flush = 0;
    idle = mk("idle", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, O_IDLE);

    sz.id_rs1 = '0; sz.id_rs2 = '0; sz.id_uses_rs1 = 1'b0; sz.id_uses_rs2 = 1'b0;
    sz.ex_rd = '0; sz.ex_mem_read = 1'b0; sz.ex_branch_taken = 1'b0;
    sz.ex_jump = 1'b0; sz.ex_mc_start = 1'b0; sz.ex_mc_cycles = '0;

    // Reset with an active jump on the inputs: outputs must still read zero.
    rst_n = 1'b0;
    drive(mk("rst_jump", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, O_IDLE));
    #2;
    check_out("reset_gated", O_IDLE);
    repeat (2) @(posedge clk);
    #1;
    check_cnt("reset_counters");
    drive(idle);
    rst_n = 1'b1;
    #1;

    vecs.push_back(mk("load_use_rs2", 5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, O_LU));
    vecs.push_back(mk("x0_no_stall",  5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, O_IDLE));
    vecs.push_back(mk("idle",         5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, O_IDLE));
    vecs.push_back(mk("rs1_unused",   5'd9, 5'd1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, O_IDLE));
    vecs.push_back(mk("load_use_rs1", 5'd9, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, O_LU));
    vecs.push_back(mk("no_load",      5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, O_IDLE));
    vecs.push_back(mk("rd31_rs2",     5'd4, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, O_LU));
    vecs.push_back(mk("branch",       5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, O_RED));
    vecs.push_back(mk("jump_mc_lu",   5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, O_RED));
    vecs.push_back(mk("after_jump",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, O_IDLE));
    vecs.push_back(mk("mc_zero",      5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, O_IDLE));
    vecs.push_back(mk("mc_zero_lu",   5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, O_LU));
    vecs.push_back(mk("x0_rs2",       5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, O_IDLE));

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
    end

    // Multi-cycle op of 3 extra cycles; redirect and load-use inputs in MC_WAIT are ignored.
    step(mk("mc3_start", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, O_MCS));
    step(mk("mc3_w1_br", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, O_MCW));
    step(mk("mc3_w2_lu", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, O_MCW));
    step(mk("mc3_w3_mc", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7, O_MCW));
    step(mk("mc3_done",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, O_IDLE));

    // Multi-cycle start outranks a simultaneous load-use match.
    step(mk("mc1_over_lu", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, O_MCS));
    step(mk("mc1_w1",      5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, O_MCW));
    step(mk("mc1_done",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, O_IDLE));

    // Reset in the 4th MC_WAIT cycle of a 10-cycle op.
    step(mk("mc10_start", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10, O_MCS));
    step(mk("mc10_w1", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, O_MCW));
    step(mk("mc10_w2", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, O_MCW));
    step(mk("mc10_w3", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, O_MCW));
    drive(idle);
    #1;
    check_out("mc10_w4", O_MCW);
    #1;
    rst_n = 1'b0;
    hz.ex_jump = 1'b1;
    #1;
    exp_stall = 0;
    exp_flush = 0;
    check_out("mid_op_reset", O_IDLE);
    check_cnt("mid_op_reset");
    @(posedge clk);
    #2;
    drive(idle);
    rst_n = 1'b1;
    step(mk("post_rst_run", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, O_IDLE));
    step(mk("post_rst_lu",  5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, O_LU));
    step(mk("post_rst_mc",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, O_MCS));
    step(mk("post_rst_w1",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, O_MCW));
    step(mk("post_rst_w2",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, O_MCW));
    step(mk("post_rst_end", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, O_IDLE));

    // 4-bit counters: 20 redirect cycles must saturate at 15.
    sz.ex_jump = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ((sz.flush_cnt !== 4'd15) || (sz.stall_cnt !== 4'd0)) begin
      errors++;
      $display("FAIL sat_flush_cnt: got flush=%0d stall=%0d want flush=15 stall=0",
               sz.flush_cnt, sz.stall_cnt);
    end
    sz.ex_jump = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001: The block SHALL provide parameter MC_W, default 4, as the width of the multi-cycle latency field.
REQ-002: The block SHALL provide parameter PERF_W, default 16, as the width of each saturating performance counter.
REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-006: id_uses_rs1, id_uses_rs2  input  1 each  ID instruction reads that source.
REQ-007: ex_rd  input  5  destination of the instruction in EX.
REQ-008: ex_mem_read  input  1  EX instruction is a load.
REQ-009: ex_branch_taken, ex_jump  input  1 each  EX resolves a taken branch or JAL.
REQ-010: ex_mc_start  input  1  EX instruction is a multi-cycle ALU op (MUL/DIV).
REQ-011: ex_mc_cycles  input  MC_W  extra EX cycles required by that op.
REQ-012: stall_if, stall_id, stall_ex  output  1 each  hold the PC, IF/ID and ID/EX registers.
REQ-013: flush_id, flush_ex  output  1 each  zero the IF/ID and ID/EX registers.
REQ-014: mc_busy  output  1  a multi-cycle op occupies EX.
REQ-015: stall_cnt, flush_cnt  output  PERF_W each  saturating event counters.

Function
REQ-016: The FSM SHALL have exactly two states, RUN and MC_WAIT, plus a down-counter mc_cnt of width MC_W.
REQ-017: Control outputs SHALL be combinational from state, mc_cnt and the inputs, with zero-cycle latency.
REQ-018: Redirect SHALL be detected in RUN when ex_branch_taken or ex_jump is 1; the block SHALL then assert flush_id=1 and flush_ex=1 with all stalls 0, and ex_mc_start SHALL be ignored.
REQ-019: Multi-cycle start SHALL be detected in RUN when there is no redirect, ex_mc_start=1 and ex_mc_cycles!=0.
REQ-020: On a multi-cycle start, the block SHALL assert stall_if, stall_id and stall_ex, load mc_cnt=ex_mc_cycles and go to MC_WAIT.
REQ-021: The block SHALL treat ex_mc_start=1 with ex_mc_cycles=0 as a single-cycle op, with no stall and no state change.
REQ-022: In MC_WAIT, the block SHALL assert stall_if, stall_id, stall_ex and mc_busy.
REQ-023: In MC_WAIT, mc_cnt SHALL decrement by one each cycle; when mc_cnt==1, the block SHALL return to RUN on the next edge with mc_cnt=0.
REQ-024: Total EX occupancy for a multi-cycle op SHALL be ex_mc_cycles+1 cycles.
REQ-025: In MC_WAIT, the block SHALL ignore ex_branch_taken, ex_jump, ex_mc_start and load-use hazards.
REQ-026: Load-use SHALL be detected in RUN when there is no redirect and no multi-cycle start, ex_mem_read=1, ex_rd!=0, and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)).
REQ-027: On load-use, the block SHALL assert stall_if=1, stall_id=1, flush_ex=1 (bubble) and stall_ex=0 for exactly one cycle, with no state change.
REQ-028: Priority SHALL be redirect > multi-cycle start > load-use.
REQ-029: A register x0 match SHALL never cause a stall.
REQ-030: The block SHALL never assert flush_ex and stall_ex in the same cycle.
REQ-031: stall_cnt SHALL increment on every cycle with stall_if=1 and saturate at all-ones.
REQ-032: flush_cnt SHALL increment on every redirect cycle and saturate at all-ones.

Reset
REQ-033: While rst_n=0, the block SHALL hold state=RUN, mc_cnt=0, stall_cnt=0 and flush_cnt=0, with every output 0 independent of clk.
REQ-034: Reset asserted during MC_WAIT SHALL abort the op immediately; the first edge after release SHALL evaluate in RUN.

Structure
REQ-035: A shared package SHALL hold the state enum (RUN, MC_WAIT), the REG_ZERO=5'd0 constant and the default MC_W and PERF_W values.
REQ-036: A single sub-module, sat_counter (parameter width, ports clk, rst_n, inc, count), SHALL be instantiated twice for the performance counters.

Verification
REQ-037: Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle of stall_if=stall_id=flush_ex=1 and stall_ex=0; stall_cnt=1.
REQ-038: x0 case: ex_mem_read=1, ex_rd=0, id_rs1=0, id_uses_rs1=1 -> no stall, all outputs 0.
REQ-039: Multi-cycle op: ex_mc_start=1, ex_mc_cycles=3 -> stalls and mc_busy high for 1+3 cycles, with mc_busy=1 only in the last 3; RUN afterwards; stall_cnt=4.
REQ-040: Simultaneous events: ex_jump=1 with ex_mc_start=1 and a load-use match in the same cycle -> flush_id=flush_ex=1, no stall, flush_cnt=1, state remains RUN.
REQ-041: Reset mid-op: ex_mc_cycles=10, rst_n pulled low in the 4th MC_WAIT cycle -> outputs 0 immediately; after release, state=RUN and mc_cnt=0.
REQ-042: Saturation: PERF_W=4, 20 consecutive redirect cycles -> flush_cnt holds 15.
